// File: rtl/uart_tx_pkg.sv
// uart_tx shared definitions: frame state encodings.
// Optional parity frame selected by defining UART_TX_PARITY_EN.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      UART_TX_IDLE   = 3'd0,
      UART_TX_START  = 3'd1,
      UART_TX_DATA   = 3'd2,
      UART_TX_PARITY = 3'd3,
      UART_TX_STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period timer for uart_tx: tick is high on the last cycle of each bit.
// Divisor values 0 and 1 both give a one-cycle bit period.
module uart_tx_baud_gen #(
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] reload;

   // Reload value is divisor-1, clamped so 0 behaves like 1
   always_comb begin
      reload = (div <= DIV_WIDTH'(1)) ? '0 : div - DIV_WIDTH'(1);
   end

   // Down-counter restarted on frame start and at every bit boundary
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load || (cnt == '0)) begin
         cnt <= reload;
      end else begin
         cnt <= cnt - DIV_WIDTH'(1);
      end
   end

   assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops the TX FIFO and shifts frames out LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] fifoDout,
   input  logic                  fifoEmpty,
   output logic                  fifoRe,
   input  logic [DIV_WIDTH-1:0]  divisor,
   output logic                  tx,
   output logic                  busy
);

   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   state_t                state;
   state_t                state_next;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shreg_next;
   logic [BIT_W-1:0]      bitcnt;
   logic [DIV_WIDTH-1:0]  divLatched;
   logic [DIV_WIDTH-1:0]  baud_div;
   logic                  tick;
   logic                  load;
   logic                  last_bit;
   logic                  tx_next;
`ifdef UART_TX_PARITY_EN
   logic                  par;
`endif

   assign last_bit = (bitcnt == BIT_W'(DATA_WIDTH - 1));

   uart_tx_baud_gen #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_baud_gen (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .div  (baud_div),
      .tick (tick)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= UART_TX_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: advance one frame field per bit tick, chain frames while FIFO has data
   always_comb begin
      state_next = state;
      case (state)
         UART_TX_IDLE: begin
            if (!fifoEmpty) state_next = UART_TX_START;
         end
         UART_TX_START: begin
            if (tick) state_next = UART_TX_DATA;
         end
         UART_TX_DATA: begin
`ifdef UART_TX_PARITY_EN
            if (tick && last_bit) state_next = UART_TX_PARITY;
`else
            if (tick && last_bit) state_next = UART_TX_STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         UART_TX_PARITY: begin
            if (tick) state_next = UART_TX_STOP;
         end
`endif
         UART_TX_STOP: begin
            if (tick) state_next = fifoEmpty ? UART_TX_IDLE : UART_TX_START;
         end
         default: state_next = UART_TX_IDLE;
      endcase
   end

   // Outputs: pop strobe, baud reload source, next shift value and next line level
   always_comb begin
      fifoRe     = 1'b0;
      load       = 1'b0;
      baud_div   = divLatched;
      shreg_next = shreg;
      tx_next    = 1'b1;
      if (!reset && !fifoEmpty &&
          ((state == UART_TX_IDLE) || ((state == UART_TX_STOP) && tick))) begin
         fifoRe = 1'b1;
      end
      load = fifoRe;
      if (load) begin
         baud_div   = divisor;
         shreg_next = fifoDout;
      end else if ((state == UART_TX_DATA) && tick && !last_bit) begin
         shreg_next = shreg >> 1;
      end
      case (state_next)
         UART_TX_START:  tx_next = 1'b0;
         UART_TX_DATA:   tx_next = shreg_next[0];
`ifdef UART_TX_PARITY_EN
         UART_TX_PARITY: tx_next = par;
`endif
         default:        tx_next = 1'b1;
      endcase
   end

   // Datapath: shift register, bit counter, latched divisor, registered line and busy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg      <= '0;
         bitcnt     <= '0;
         divLatched <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
      end else begin
         shreg <= shreg_next;
         tx    <= tx_next;
         busy  <= (state_next != UART_TX_IDLE);
         if (load) begin
            divLatched <= divisor;
            bitcnt     <= '0;
         end else if ((state == UART_TX_DATA) && tick) begin
            bitcnt <= last_bit ? '0 : bitcnt + BIT_W'(1);
         end
      end
   end

`ifdef UART_TX_PARITY_EN
   // Even parity of the byte, captured when it is popped
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par <= 1'b0;
      end else if (load) begin
         par <= ^fifoDout;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model, serial-line decoder, byte scoreboard.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
module tb_uart_tx;

   localparam int unsigned DW  = 8;
   localparam int unsigned DVW = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   localparam int NFRAMES = 7;
`else
   localparam int NB = 10;
   localparam int NFRAMES = 6;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [DW-1:0]  fifoDout = '0;
   logic           fifoEmpty = 1'b1;
   logic           fifoRe;
   logic [DVW-1:0] divisor = 16'd4;
   logic           tx;
   logic           busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   int         exp_head = 0;
   logic       push_stb = 1'b0;
   logic [7:0] push_byte = '0;
   logic       pend_pop = 1'b0;
   int         re_cnt = 0;
   int         re_gap = 0;
   int         last_re_cyc = 0;
   int         frames_done = 0;
   int         start_prev = 0;
   int         start_last = 0;

   uart_tx #(
      .DATA_WIDTH(DW),
      .DIV_WIDTH (DVW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .fifoDout (fifoDout),
      .fifoEmpty(fifoEmpty),
      .fifoRe   (fifoRe),
      .divisor  (divisor),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      exp_q.push_back(b);
      push_byte = b;
      push_stb  = 1'b1;
      tick();
      push_stb  = 1'b0;
   endtask

   task automatic busy_len(output int len);
      int t;
      t   = 0;
      len = 0;
      while (busy !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      while (busy === 1'b1 && len < 500) begin
         tick();
         len++;
      end
   endtask

   // FIFO model: pops after an edge that saw fifoRe, accepts pushes, presents FWFT data
   always begin
      @(negedge clk);
      if (pend_pop && fifo_q.size() > 0) begin
         void'(fifo_q.pop_front());
         re_cnt++;
         re_gap      = cyc - last_re_cyc;
         last_re_cyc = cyc;
      end
      if (push_stb) fifo_q.push_back(push_byte);
      fifoEmpty = (fifo_q.size() == 0);
      fifoDout  = fifoEmpty ? 8'h00 : fifo_q[0];
      #2;
      pend_pop = fifoRe;
      if (fifoRe === 1'b1) check("re_while_empty", int'(fifoEmpty), 0);
   end

   // Line decoder: samples every cycle of a frame, checks bit hold, busy and framing
   logic [10:0] bits;
   logic [7:0]  data;
   logic [7:0]  expb;
   int          d;
   int          n;
   bit          aborted;
   bit          stable;
   bit          busy_ok;

   always begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
         d          = (divisor < 16'd2) ? 1 : int'(divisor);
         start_prev = start_last;
         start_last = cyc;
         n          = NB * d;
         aborted    = 1'b0;
         stable     = 1'b1;
         busy_ok    = 1'b1;
         bits       = '0;
         for (int k = 0; k < n && !aborted; k++) begin
            if (k > 0) @(negedge clk);
            if (reset === 1'b1) begin
               aborted = 1'b1;
            end else begin
               if (k % d == 0) bits[k / d] = tx;
               else if (tx !== bits[k / d]) stable = 1'b0;
               if (busy !== 1'b1) busy_ok = 1'b0;
            end
         end
         if (aborted) begin
            exp_head++;
         end else begin
            data = bits[8:1];
            expb = 8'h00;
            if (exp_head < exp_q.size()) begin
               expb = exp_q[exp_head];
               exp_head++;
               check("rx_data", int'(data), int'(expb));
            end else begin
               check("rx_unexpected_frame", 1, 0);
            end
            check("rx_bit_hold", int'(stable), 1);
            check("rx_busy_in_frame", int'(busy_ok), 1);
            check("rx_stop", int'(bits[NB-1]), 1);
`ifdef UART_TX_PARITY_EN
            check("rx_parity", int'(bits[9]), int'(^expb));
`endif
            frames_done++;
         end
      end
   end

   int len;
   int r0;
   int t;

   initial begin
      // reset state, then idle with empty FIFO
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", int'(tx), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_re", int'(fifoRe), 0);
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_tx", int'(tx), 1);
         check("idle_busy", int'(busy), 0);
         check("idle_re", int'(fifoRe), 0);
      end

      // divisor 4, single 0x55
      divisor = 16'd4;
      r0 = re_cnt;
      push(8'h55);
      busy_len(len);
      check("len_55", len, NB * 4);
      tick(3);
      check("re_count_55", re_cnt - r0, 1);
      check("idle_after_55", int'(tx), 1);

      // divisor 2, two bytes back to back
      divisor = 16'd2;
      r0 = re_cnt;
      push(8'hA5);
      push(8'h3C);
      busy_len(len);
      check("len_pair", len + 1, 2 * NB * 2);
      tick(3);
      check("re_count_pair", re_cnt - r0, 2);
      check("re_spacing", re_gap, NB * 2);
      check("frame_spacing", start_last - start_prev, NB * 2);

      // divisor 0 behaves as 1
      divisor = 16'd0;
      push(8'hFF);
      busy_len(len);
      check("len_div0", len, NB);
      tick(2);
      check("idle_after_ff", int'(tx), 1);
      check("busy_after_ff", int'(busy), 0);

      // reset mid-DATA: line returns high at once, next byte still goes out
      divisor = 16'd4;
      r0 = re_cnt;
      push(8'h96);
      push(8'h4B);
      tick(4);
      check("busy_96", int'(busy), 1);
      check("pre_rst_tx", int'(tx), 0);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_tx", int'(tx), 1);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_re", int'(fifoRe), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_hold_re", int'(fifoRe), 0);
         check("rst_hold_tx", int'(tx), 1);
      end
      check("re_count_in_rst", re_cnt - r0, 1);
      reset = 1'b0;
      busy_len(len);
      check("len_after_rst", len, NB * 4);
      tick(3);
      check("re_count_after_rst", re_cnt - r0, 2);

      // divisor change mid-frame is ignored
      divisor = 16'd3;
      push(8'hC3);
      t   = 0;
      len = 0;
      while (busy !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      while (busy === 1'b1 && len < 500) begin
         if (len == 5) divisor = 16'd9;
         tick();
         len++;
      end
      check("len_div_change", len, NB * 3);
      divisor = 16'd3;
      tick(2);

`ifdef UART_TX_PARITY_EN
      // parity frame: 0x07 has odd weight so parity bit is 1
      divisor = 16'd3;
      push(8'h07);
      busy_len(len);
      check("len_parity", len, 33);
      tick(2);
`endif

      tick(5);
      check("frames_done", frames_done, NFRAMES);
      check("scoreboard_drained", exp_head, exp_q.size());
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
